// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: turns fetch, load-use, multi-cycle and branch events into
// hold/flush controls for IF/ID and ID/EX, with saturating stall and flush counters.
module pipe_stall_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int LU_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        load_use_hazard,
    input  logic        mc_busy,
    input  logic        branch_taken,
    input  logic        cnt_clr,
    output logic        staller,
    output logic        pc_hold,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        IMEM_WAIT = 3'd1,
        LU_STALL  = 3'd2,
        MC_STALL  = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    // Cycle-one of each flush/stall is spent in RUN, so the counter preloads two short.
    localparam logic [2:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [2:0] LU_INIT    = (LU_CYCLES > 1) ? 3'(LU_CYCLES - 2) : 3'd0;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_cycles;

    state_t      w_next_state;
    logic [2:0]  w_next_cnt;
    logic        w_hold;
    logic        w_flush;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_hold       = 1'b0;
        w_flush      = 1'b0;
        if (branch_taken) begin
            w_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state = FLUSH;
                w_next_cnt   = FLUSH_INIT;
            end else begin
                w_next_state = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (mc_busy) begin
                        w_hold       = 1'b1;
                        w_next_state = MC_STALL;
                    end else if (load_use_hazard) begin
                        w_hold = 1'b1;
                        if (LU_CYCLES > 1) begin
                            w_next_state = LU_STALL;
                            w_next_cnt   = LU_INIT;
                        end
                    end else if (!imem_ready) begin
                        w_hold       = 1'b1;
                        w_next_state = IMEM_WAIT;
                    end
                end
                IMEM_WAIT: begin
                    if (!imem_ready) w_hold = 1'b1;
                    else             w_next_state = RUN;
                end
                LU_STALL: begin
                    w_hold = 1'b1;
                    if (r_cnt == 3'd0) w_next_state = RUN;
                    else               w_next_cnt   = r_cnt - 3'd1;
                end
                MC_STALL: begin
                    if (mc_busy) w_hold = 1'b1;
                    else         w_next_state = RUN;
                end
                FLUSH: begin
                    w_flush = 1'b1;
                    if (r_cnt == 3'd0) w_next_state = RUN;
                    else               w_next_cnt   = r_cnt - 3'd1;
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Controls are masked by reset so a held core never sees a stray stall or flush.
    assign staller      = w_hold & rst_n;
    assign pc_hold      = w_hold & rst_n;
    assign id_ex_bubble = w_hold & rst_n;
    assign if_id_flush  = w_flush & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
            r_flush_cycles <= 16'd0;
        end else if (cnt_clr) begin
            r_stall_cycles <= 16'd0;
            r_flush_cycles <= 16'd0;
        end else begin
            if (staller && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (if_id_flush && r_flush_cycles != 16'hFFFF)
                r_flush_cycles <= r_flush_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
    assign state        = r_state;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, range 1..7: cycles if_id_flush stays asserted per taken branch.
REQ-002 The block SHALL have parameter LU_CYCLES, default 1, range 1..7: cycles of hold per load-use hazard.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_ready  in  1  instruction memory has valid 160-bit fetch data this cycle.
REQ-006 The block SHALL have port load_use_hazard  in  1  ID instruction depends on a load in EX.
REQ-007 The block SHALL have port mc_busy  in  1  multi-cycle EX unit occupied.
REQ-008 The block SHALL have port branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-009 The block SHALL have port cnt_clr  in  1  synchronous clear of both performance counters.
REQ-010 The block SHALL have port staller  out  1  hold IF/ID register (1 = keep PC/instruction bundle).
REQ-011 The block SHALL have port pc_hold  out  1  inhibit PC update.
REQ-012 The block SHALL have port if_id_flush  out  1  zero the IF/ID contents.
REQ-013 The block SHALL have port id_ex_bubble  out  1  insert NOP into ID/EX.
REQ-014 The block SHALL have port stall_cycles  out  16  cycles with staller=1.
REQ-015 The block SHALL have port flush_cycles  out  16  cycles with if_id_flush=1.
REQ-016 The block SHALL have port state  out  3  current FSM state encoding.

Function
REQ-017 The FSM SHALL have states RUN=0, IMEM_WAIT=1, LU_STALL=2, MC_STALL=3, FLUSH=4, plus a 3-bit down-counter cnt.
REQ-018 The control outputs SHALL be combinational from (state, inputs); "hold" means staller=pc_hold=id_ex_bubble=1, if_id_flush=0.
REQ-019 The block SHALL apply branch_taken at highest priority in every state: if_id_flush=1, staller=pc_hold=id_ex_bubble=0; if FLUSH_CYCLES>1 then next=FLUSH with cnt=FLUSH_CYCLES-2, else next=RUN.
REQ-020 In RUN without a branch, priority SHALL be mc_busy > load_use_hazard > !imem_ready; the first true one asserts hold in the same cycle.
REQ-021 From RUN, mc_busy SHALL go next=MC_STALL.
REQ-022 From RUN, load_use_hazard SHALL go next=LU_STALL with cnt=LU_CYCLES-2 when LU_CYCLES>1, else remain RUN.
REQ-023 From RUN, !imem_ready SHALL go next=IMEM_WAIT.
REQ-024 In RUN with no condition true, all control outputs SHALL be 0.
REQ-025 FLUSH SHALL assert if_id_flush=1 with other controls 0; cnt==0 -> RUN, else cnt decrements.
REQ-026 LU_STALL SHALL assert hold; cnt==0 -> RUN, else cnt decrements.
REQ-027 MC_STALL SHALL assert hold while mc_busy=1; the cycle mc_busy=0 deasserts all controls and goes to RUN.
REQ-028 IMEM_WAIT SHALL assert hold while imem_ready=0; the cycle imem_ready=1 deasserts all controls and goes to RUN.
REQ-029 load_use_hazard and imem_ready SHALL be ignored in MC_STALL, FLUSH and LU_STALL, except for the exit rules above.
REQ-030 stall_cycles SHALL increment on each clock where staller=1; flush_cycles SHALL increment on each clock where if_id_flush=1; both saturate at 0xFFFF (no wrap).
REQ-031 cnt_clr=1 SHALL zero both counters on the next edge, taking priority over an increment in the same cycle.
REQ-032 An unused state encoding (5..7) SHALL force next=RUN with all controls 0.

Reset
REQ-033 rst_n=0 SHALL asynchronously set state=RUN, cnt=0, stall_cycles=0, flush_cycles=0.
REQ-034 While rst_n=0, staller, pc_hold, if_id_flush and id_ex_bubble SHALL be forced to 0 regardless of inputs.
REQ-035 Reset asserted mid-stall or mid-flush SHALL abort it immediately; after release, operation SHALL resume from RUN on the first rising edge.

Verification
REQ-036 Bench SHALL cover load-use: defaults, pulse load_use_hazard for 1 cycle in RUN -> staller=1 for exactly 1 cycle, state stays 0, stall_cycles=1.
REQ-037 Bench SHALL cover flush: FLUSH_CYCLES=3, branch_taken pulse -> if_id_flush=1 for 3 consecutive cycles, state 0->4->4->0, flush_cycles=3.
REQ-038 Bench SHALL cover priority: mc_busy=1 and branch_taken=1 in the same cycle -> flush wins, staller=0; later mc_busy=1 for 4 cycles -> staller high 4 cycles, released in the cycle mc_busy falls.
REQ-039 Bench SHALL cover imem: imem_ready low 5 cycles, then high -> hold for 5 cycles, controls 0 in the ready cycle, state returns to 0.
REQ-040 Bench SHALL cover saturation and clear: preload 0xFFFE stall cycles plus 3 more -> stall_cycles=0xFFFF; cnt_clr during a stall -> 0 next edge.
REQ-041 Bench SHALL cover mid-operation reset: rst_n low during LU_STALL (LU_CYCLES=4) -> outputs 0 immediately, state=0, counters 0.
